// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped timer: FSM states, register word
// offsets, CTRL bit positions and mode encodings.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

  // Modes 2 and 3 are reserved and fall back to one-shot behaviour.
  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_RELOAD  = 2'd1,
    MODE_RSVD2   = 2'd2,
    MODE_RSVD3   = 2'd3
  } mode_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_IM_BIT   = 3;

  function automatic logic is_reload(input logic [1:0] mode);
    return mode == MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt line; registers and FSM share one clocked process.
module timer_counter
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  logic        r_enable;
  logic [1:0]  r_mode;
  logic        r_im;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_pending;
  state_e      r_state;

  logic [31:0] w_ctrl;
  logic [31:0] w_dout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_enable      <= 1'b0;
      r_mode        <= 2'd0;
      r_im          <= 1'b0;
      r_preset      <= 32'd0;
      r_count       <= 32'd0;
      r_irq_pending <= 1'b0;
      r_state       <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_enable) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!r_enable) begin
            r_state <= ST_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            r_count       <= 32'd0;
            r_irq_pending <= 1'b1;
            r_state       <= ST_INT;
          end
        end
        ST_INT: begin
          if (is_reload(r_mode)) begin
            r_irq_pending <= 1'b0;
            r_state       <= ST_LOAD;
          end else begin
            r_enable <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // NOTE: non-blocking assignments, so the bus write below is the last
      // assignment in the block and overrides the FSM's Enable clear and
      // irq_pending set when both land on the same edge.
      if (WE) begin
        case (Addr)
          ADDR_CTRL: begin
            r_enable      <= DIn[CTRL_EN_BIT];
            r_mode        <= DIn[CTRL_MODE_LSB +: 2];
            r_im          <= DIn[CTRL_IM_BIT];
            r_irq_pending <= 1'b0;
          end
          ADDR_PRESET: begin
            r_preset      <= DIn;
            r_irq_pending <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign w_ctrl = {28'd0, r_im, r_mode, r_enable};

  always_comb begin
    w_dout = 32'd0;
    case (Addr)
      ADDR_CTRL:   w_dout = w_ctrl;
      ADDR_PRESET: w_dout = r_preset;
      ADDR_COUNT:  w_dout = r_count;
      ADDR_RSVD:   w_dout = 32'd0;
      default:     w_dout = 32'd0;
    endcase
  end

  assign DOut = w_dout;
  assign IRQ  = r_im & r_irq_pending;

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter: reset/read-back, one-shot,
// auto-reload, masking, disable mid-count and boundary cases.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  int n_cmp;
  int n_fail;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .DIn  (DIn),
    .DOut (DOut),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1ns past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // The write lands on the next rising edge; returns 1ns after it.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a;
    DIn  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE  = 1'b0;
    DIn = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = DOut;
  endtask

  // Reset released 1ns after a rising edge, so the next edge is the first one.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] exp_cnt [10];
    logic        exp_irq [10];
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    Addr   = 2'd0;
    WE     = 1'b0;
    DIn    = 32'd0;

    // ---- Reset state and read-back
    #2;
    chk_reg("rst_ctrl", 2'd0, 32'd0);
    check("rst_irq", {31'd0, IRQ}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    wr(2'd1, 32'h10);
    chk_reg("first_edge_preset", 2'd1, 32'h10);
    chk_reg("count_idle", 2'd2, 32'h0);
    wr(2'd0, 32'hE);
    chk_reg("ctrl_readback", 2'd0, 32'hE);
    wr(2'd0, 32'hFFFF_FFF6);
    chk_reg("ctrl_upper_ignored", 2'd0, 32'h6);
    #2;
    reset = 1'b0;
    chk_reg("async_rst_ctrl", 2'd0, 32'd0);
    chk_reg("async_rst_preset", 2'd1, 32'd0);
    chk_reg("async_rst_count", 2'd2, 32'd0);
    chk_reg("async_rst_rsvd", 2'd3, 32'd0);
    check("async_rst_irq", {31'd0, IRQ}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // ---- Mode 0 one-shot, N=5
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);                       // edge W
    tick(2);
    chk_reg("m0_count_w2", 2'd2, 32'd5);
    check("m0_irq_w2", {31'd0, IRQ}, 32'd0);
    tick(4);
    chk_reg("m0_count_w6", 2'd2, 32'd1);
    check("m0_irq_w6", {31'd0, IRQ}, 32'd0);
    tick(1);
    chk_reg("m0_count_w7", 2'd2, 32'd0);
    check("m0_irq_w7", {31'd0, IRQ}, 32'd1);
    tick(1);
    chk_reg("m0_ctrl_after", 2'd0, 32'h8);
    check("m0_irq_held", {31'd0, IRQ}, 32'd1);
    tick(3);
    check("m0_irq_held_late", {31'd0, IRQ}, 32'd1);
    chk_reg("m0_count_idle", 2'd2, 32'd0);
    wr(2'd1, 32'd7);
    check("m0_irq_cleared", {31'd0, IRQ}, 32'd0);

    // ---- Mode 1 auto-reload, N=3: period 5
    do_reset();
    exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);                       // edge W
    tick(2);
    for (int i = 0; i < 10; i++) begin
      chk_reg($sformatf("m1_count_w%0d", i + 2), 2'd2, exp_cnt[i]);
      check($sformatf("m1_irq_w%0d", i + 2), {31'd0, IRQ}, {31'd0, exp_irq[i]});
      if (i < 9) tick(1);
    end

    // ---- Mask: IM=0, then CTRL=0x8 clears pending
    do_reset();
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);                       // edge W
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check($sformatf("mask_irq_w%0d", i), {31'd0, IRQ}, 32'd0);
    end
    chk_reg("mask_ctrl_after", 2'd0, 32'h0);
    wr(2'd0, 32'h8);
    check("mask_irq_after_im", {31'd0, IRQ}, 32'd0);
    tick(2);
    check("mask_irq_still0", {31'd0, IRQ}, 32'd0);

    // ---- Disable mid-count at COUNT=60
    do_reset();
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);                       // edge W
    tick(42);
    chk_reg("dis_count60", 2'd2, 32'd60);
    wr(2'd0, 32'h0);                       // edge W+43
    chk_reg("dis_count59", 2'd2, 32'd59);
    tick(20);
    chk_reg("dis_count_hold", 2'd2, 32'd59);
    check("dis_irq", {31'd0, IRQ}, 32'd0);

    // ---- PRESET=0: INT at W+3
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);                       // edge W
    tick(2);
    check("n0_irq_w2", {31'd0, IRQ}, 32'd0);
    tick(1);
    check("n0_irq_w3", {31'd0, IRQ}, 32'd1);

    // ---- PRESET write during CNT, ignored writes, CTRL-write precedence
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);                       // edge W
    tick(2);
    chk_reg("pre_count_w2", 2'd2, 32'd10);
    wr(2'd1, 32'h20);                      // edge W+3
    chk_reg("pre_count_w3", 2'd2, 32'd9);
    chk_reg("pre_preset_new", 2'd1, 32'h20);
    tick(1);
    wr(2'd2, 32'h1234);                    // edge W+5
    chk_reg("wr_count_ignored", 2'd2, 32'd7);
    wr(2'd3, 32'hFFFF_FFFF);               // edge W+6
    chk_reg("wr_rsvd_count", 2'd2, 32'd6);
    chk_reg("wr_rsvd_read0", 2'd3, 32'd0);
    chk_reg("wr_rsvd_ctrl", 2'd0, 32'h9);
    tick(5);
    check("pre_irq_w11", {31'd0, IRQ}, 32'd0);
    tick(1);
    check("pre_irq_w12", {31'd0, IRQ}, 32'd1);
    wr(2'd0, 32'h9);                       // edge W+13, INT-state clear collides
    chk_reg("prec_ctrl", 2'd0, 32'h9);
    check("prec_irq_cleared", {31'd0, IRQ}, 32'd0);
    tick(2);
    chk_reg("prec_reload_new_preset", 2'd2, 32'h20);

    // ---- Reset mid-count aborts; block stays idle afterwards
    tick(3);
    #2;
    reset = 1'b0;
    chk_reg("abort_count", 2'd2, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(5);
    chk_reg("abort_idle_count", 2'd2, 32'd0);
    check("abort_idle_irq", {31'd0, IRQ}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL be the memory-mapped timer device that consumes the CPU's processor-bus writes, via the bridge, and returns read data and one hardware interrupt line.
REQ-002 Port list, in order:
- clk  input  1  the single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-low reset
- Addr  input  2  word select (bus address bits [3:2]); base-address decode is done by the bridge
- WE  input  1  write enable, already qualified by the bridge decode
- DIn  input  32  write data
- DOut  output  32  read data
- IRQ  output  1  interrupt request, routed by the bridge to one HWInt bit
REQ-003 Parameters: none.

Function
REQ-004 Register map:
- Addr 0: CTRL. Bit 0 = Enable, bits [2:1] = Mode, bit 3 = IM (interrupt mask). Other bits read 0; writes to them are ignored.
- Addr 1: PRESET, 32-bit, read/write.
- Addr 2: COUNT, 32-bit, read-only; writes are ignored.
- Addr 3: reads 0; writes are ignored.
REQ-005 DOut SHALL be a combinational decode of Addr, with no read latency.
REQ-006 A write SHALL take effect at the rising edge on which WE=1.
REQ-007 FSM states: IDLE, LOAD, CNT, INT.
REQ-008 IDLE: if Enable=1, go to LOAD on the next edge; otherwise stay, with COUNT held.
REQ-009 LOAD: COUNT<=PRESET, then go to CNT.
REQ-010 CNT, when Enable=0: go to IDLE, with COUNT held.
REQ-011 CNT, when Enable=1 and COUNT>1: COUNT<=COUNT-1.
REQ-012 CNT, when Enable=1 and COUNT<=1: COUNT<=0, irq_pending<=1, go to INT.
REQ-013 INT, Mode 0 (one-shot): Enable<=0, go to IDLE; irq_pending is held.
REQ-014 INT, Mode 1 (auto-reload): irq_pending<=0, go to LOAD; in this mode irq_pending lasts exactly one cycle.
REQ-015 Mode values 2 and 3 SHALL behave as Mode 0.
REQ-016 A write to CTRL or PRESET SHALL clear irq_pending.
REQ-017 IRQ SHALL equal IM AND irq_pending, combinationally.
REQ-018 If a CTRL write and the INT-state Enable clear occur on the same edge, the software write SHALL take precedence.
REQ-019 A PRESET write during CNT SHALL NOT alter COUNT; it applies only at the next LOAD.
REQ-020 Timing, with W = the edge on which Enable=1 is written and PRESET=N:
- LOAD at W+1
- CNT with COUNT=N at W+2
- INT with COUNT=0 and IRQ=1 (if IM=1) at W+2+N for N>=1, and at W+3 for N=0
REQ-021 In Mode 1 the interrupt period SHALL be N+2 cycles for N>=1.
REQ-022 Decrement SHALL be unsigned 32-bit and SHALL never wrap below 0.

Reset
REQ-023 While reset=0, the following SHALL hold immediately and asynchronously:
- CTRL=0, PRESET=0, COUNT=0
- irq_pending=0, state=IDLE
- IRQ=0; DOut reflects the zeroed registers
REQ-024 Reset asserted mid-count SHALL abort the count. After release, the block stays in IDLE until software sets Enable.
REQ-025 The first edge after reset release SHALL already accept writes.

Structure
REQ-026 Shared package timer_pkg SHALL hold:
- FSM state encodings
- register word offsets (0–3)
- CTRL bit positions
- Mode encodings
REQ-027 The block SHALL be a single module with no sub-modules.
REQ-028 Registers and the FSM SHALL be in one sequential process. The DOut mux and IRQ SHALL be combinational.

Verification
REQ-029 Reset and read-back:
- Stimulus: write PRESET=0x10; read Addr 1 and Addr 2.
- Required response: reads 0x10 and 0x0.
- Stimulus: then reset=0.
- Required response: all reads return 0 and IRQ=0 without any clock edge.
REQ-030 Mode 0 one-shot:
- Stimulus: PRESET=5; CTRL=0x9 (Enable, IM, Mode 0) at edge W.
- Required response: COUNT=5 at W+2; IRQ rises at W+7; CTRL reads 0x8 afterwards.
- Stimulus: write PRESET.
- Required response: IRQ drops on that edge.
REQ-031 Mode 1 auto-reload:
- Stimulus: PRESET=3; CTRL=0xB.
- Required response: IRQ is one-cycle pulses every 5 cycles; COUNT sequence 3,2,1,0,(LOAD),3...
REQ-032 Mask:
- Stimulus: CTRL=0x1, PRESET=2.
- Required response: IRQ stays 0.
- Stimulus: then write CTRL=0x8.
- Required response: irq_pending is cleared by the write, and IRQ stays 0.
REQ-033 Disable mid-count:
- Stimulus: PRESET=100; enable; write CTRL=0x0 when COUNT=60.
- Required response: state IDLE; COUNT holds 59 indefinitely; no IRQ.
REQ-034 Boundaries:
- Stimulus: PRESET=0.
- Required response: INT at W+3.
- Stimulus: PRESET write of 0x20 during CNT.
- Required response: current count is unaffected.
- Stimulus: write to Addr 2 or 3.
- Required response: no state change.
